// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST engine.
//   state_t : FSM state encoding (IDLE/SETTLE/CHECK/DONE)
//   TT_*    : 2-input truth tables indexed by {a,b}; bit0 is the output for a=0,b=0.
package gate_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that times how long each stimulus vector is held.
//   clk, rst   : clock, synchronous active-high reset (count -> 0)
//   load       : load load_val (wins over dec)
//   load_val   : reload value
//   dec        : decrement by one when nonzero
//   zero       : count is zero
module bist_settle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)                  cnt <= '0;
    else if (load)            cnt <= load_val;
    else if (dec && cnt != 0) cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/gate_bist.sv
// Self-checking stimulus engine for 2-input gates. Sweeps {a,b} through
// 00,01,10,11, holds each vector SETTLE_CYCLES cycles, then samples all
// N_DUT instance outputs for one cycle against TRUTH.
//   clk, rst         : clock, synchronous active-high reset
//   start            : request a sweep (accepted in IDLE or DONE)
//   a, b             : shared stimulus to all instances
//   c_in             : instance outputs, bit i = instance i
//   busy             : sweep in progress
//   done             : sweep complete, sticky until next start or rst
//   pass             : done with no mismatches
//   fail_mask        : per-instance sticky mismatch flags
//   first_fail_vec   : {a,b} of first vector that mismatched anywhere
//   first_fail_valid : first_fail_vec is meaningful
module gate_bist
  import gate_bist_pkg::*;
#(
  parameter int         N_DUT         = 3,
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] TRUTH         = TT_NOR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             a,
  output logic             b,
  input  logic [N_DUT-1:0] c_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [N_DUT-1:0] fail_mask,
  output logic [1:0]       first_fail_vec,
  output logic             first_fail_valid
);

  localparam int           TW     = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [TW-1:0] RELOAD = TW'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [1:0]       vec_q, vec_d;
  logic             busy_d, done_d;
  logic [N_DUT-1:0] fail_mask_d;
  logic [1:0]       ffv_d;
  logic             ffvalid_d;
  logic             tmr_load, tmr_dec, tmr_zero;
  logic             exp_bit;
  logic [N_DUT-1:0] mismatch;

  bist_settle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (RELOAD),
    .dec      (tmr_dec),
    .zero     (tmr_zero)
  );

  // Expected output for the vector currently on a/b; one comparator per lane.
  assign exp_bit = TRUTH[vec_q];

  for (genvar i = 0; i < N_DUT; i++) begin : g_lane
    assign mismatch[i] = c_in[i] ^ exp_bit;
  end

  // a/b are simply the registered vector index, so they reset to 00 and
  // naturally stay at 11 once the sweep finishes.
  assign a    = vec_q[1];
  assign b    = vec_q[0];
  assign pass = done && (fail_mask == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= IDLE;
      vec_q            <= 2'b00;
      busy             <= 1'b0;
      done             <= 1'b0;
      fail_mask        <= '0;
      first_fail_vec   <= 2'b00;
      first_fail_valid <= 1'b0;
    end else begin
      state_q          <= state_d;
      vec_q            <= vec_d;
      busy             <= busy_d;
      done             <= done_d;
      fail_mask        <= fail_mask_d;
      first_fail_vec   <= ffv_d;
      first_fail_valid <= ffvalid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    busy_d      = busy;
    done_d      = done;
    fail_mask_d = fail_mask;
    ffv_d       = first_fail_vec;
    ffvalid_d   = first_fail_valid;
    tmr_load    = 1'b0;
    tmr_dec     = 1'b0;

    unique case (state_q)
      // A restart from DONE wipes the previous results on the same edge.
      IDLE, DONE: begin
        if (start) begin
          state_d     = SETTLE;
          vec_d       = 2'b00;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          fail_mask_d = '0;
          ffv_d       = 2'b00;
          ffvalid_d   = 1'b0;
          tmr_load    = 1'b1;
        end
      end

      // start is deliberately ignored here and in CHECK.
      SETTLE: begin
        if (tmr_zero) state_d = CHECK;
        else          tmr_dec = 1'b1;
      end

      CHECK: begin
        fail_mask_d = fail_mask | mismatch;
        if ((mismatch != '0) && !first_fail_valid) begin
          ffv_d     = vec_q;
          ffvalid_d = 1'b1;
        end
        if (vec_q == 2'd3) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d  = SETTLE;
          vec_d    = vec_q + 2'd1;
          tmr_load = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_gate_bist.sv
module tb_gate_bist;

  localparam logic [3:0] G_NOR  = 4'b0001;
  localparam logic [3:0] G_OR   = 4'b1110;
  localparam logic [3:0] G_NAND = 4'b0111;

  logic       clk = 1'b0;
  logic       rst, start, start2;
  logic       a, b, busy, done, pass, ffvalid;
  logic [2:0] c_in, fail_mask;
  logic [1:0] ffv;
  logic       a2, b2, busy2, done2, pass2, ffvalid2;
  logic [0:0] c_in2, fail_mask2;
  logic [1:0] ffv2;
  logic [3:0] tt [3];
  int         total = 0;
  int         bad   = 0;

  always #5 clk = ~clk;

  // Gate models: instance i behaves per truth table tt[i], indexed by {a,b}.
  always_comb begin
    for (int i = 0; i < 3; i++) c_in[i] = tt[i][{a, b}];
  end
  assign c_in2[0] = a2 ^ b2;

  gate_bist dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .pass(pass), .fail_mask(fail_mask),
    .first_fail_vec(ffv), .first_fail_valid(ffvalid)
  );

  gate_bist #(.N_DUT(1), .SETTLE_CYCLES(1), .TRUTH(4'b0110)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .c_in(c_in2),
    .busy(busy2), .done(done2), .pass(pass2), .fail_mask(fail_mask2),
    .first_fail_vec(ffv2), .first_fail_valid(ffvalid2)
  );

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic all_nor;
    for (int i = 0; i < 3; i++) tt[i] = G_NOR;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; start2 = 1'b0; all_nor();
    tick(); tick();
    total++; if ({a, b, busy, done, pass, fail_mask, ffv, ffvalid} !== 11'b0) begin bad++; $display("FAIL reset_outs got=%b exp=0", {a, b, busy, done, pass, fail_mask, ffv, ffvalid}); end
    total++; if ({a2, b2, busy2, done2, pass2, fail_mask2, ffv2, ffvalid2} !== 9'b0) begin bad++; $display("FAIL reset_outs2 got=%b exp=0", {a2, b2, busy2, done2, pass2, fail_mask2, ffv2, ffvalid2}); end
    rst = 1'b0; tick();
  endtask

  task automatic test_all_nor;
    logic [1:0] eab;
    all_nor();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      eab = (k == 13) ? 2'd3 : 2'((k - 1) / 3);
      total++; if ({a, b} !== eab) begin bad++; $display("FAIL nor_ab cyc=%0d got=%b exp=%b", k, {a, b}, eab); end
      total++; if (busy !== (k < 13)) begin bad++; $display("FAIL nor_busy cyc=%0d got=%b", k, busy); end
      total++; if (done !== (k == 13)) begin bad++; $display("FAIL nor_done cyc=%0d got=%b", k, done); end
      if (k < 13) tick();
    end
    total++; if ({pass, fail_mask, ffvalid} !== 5'b1_000_0) begin bad++; $display("FAIL nor_result got=%b exp=10000", {pass, fail_mask, ffvalid}); end
  endtask

  task automatic test_or_inst1;
    all_nor(); tt[1] = G_OR;
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    total++; if ({done, pass, fail_mask} !== 5'b1_0_010) begin bad++; $display("FAIL or1_mask got=%b exp=10010", {done, pass, fail_mask}); end
    total++; if ({ffvalid, ffv} !== 3'b1_00) begin bad++; $display("FAIL or1_first got=%b exp=100", {ffvalid, ffv}); end
  endtask

  task automatic test_nand_inst2;
    all_nor(); tt[2] = G_NAND;
    start = 1'b1; tick(); start = 1'b0;
    repeat (12) tick();
    total++; if ({done, pass, fail_mask} !== 5'b1_0_100) begin bad++; $display("FAIL nand2_mask got=%b exp=10100", {done, pass, fail_mask}); end
    total++; if ({ffvalid, ffv} !== 3'b1_01) begin bad++; $display("FAIL nand2_first got=%b exp=101", {ffvalid, ffv}); end
  endtask

  // Instance 0 is wrong only during SETTLE cycles; the sweep must still pass.
  task automatic test_settle_ignore;
    all_nor();
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tt[0] = ((k - 1) % 3 == 2) ? G_NOR : G_OR;
      tick();
    end
    tt[0] = G_NOR;
    total++; if ({done, pass, fail_mask, ffvalid} !== 6'b11_000_0) begin bad++; $display("FAIL settle_ignore got=%b exp=110000", {done, pass, fail_mask, ffvalid}); end
  endtask

  task automatic test_reset_mid;
    all_nor(); tt[1] = G_OR;
    start = 1'b1; tick(); start = 1'b0;
    repeat (6) tick();
    total++; if ({busy, fail_mask} !== 4'b1_010) begin bad++; $display("FAIL rmid_before got=%b exp=1010", {busy, fail_mask}); end
    rst = 1'b1; tick(); rst = 1'b0;
    total++; if ({a, b, busy, done, pass, fail_mask, ffv, ffvalid} !== 11'b0) begin bad++; $display("FAIL rmid_after got=%b exp=0", {a, b, busy, done, pass, fail_mask, ffv, ffvalid}); end
    tick();
    total++; if ({busy, a, b} !== 3'b000) begin bad++; $display("FAIL rmid_idle got=%b exp=000", {busy, a, b}); end
    all_nor();
    start = 1'b1; tick(); start = 1'b0;
    repeat (11) tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_early got=%b exp=0", done); end
    tick();
    total++; if ({done, pass} !== 2'b11) begin bad++; $display("FAIL rmid_rerun got=%b exp=11", {done, pass}); end
    // rst and start together: rst wins, nothing starts.
    rst = 1'b1; start = 1'b1; tick(); rst = 1'b0; start = 1'b0;
    tick();
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL rst_start got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_start_busy;
    all_nor(); tt[2] = G_OR;
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (7) tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL busy_early got=%b exp=0", done); end
    tick();
    total++; if ({done, fail_mask, ffvalid, ffv} !== 7'b1_100_1_00) begin bad++; $display("FAIL busy_ignored got=%b exp=1100100", {done, fail_mask, ffvalid, ffv}); end
    all_nor();
    start = 1'b1; tick(); start = 1'b0;
    total++; if ({done, busy, fail_mask, ffvalid} !== 6'b0_1_000_0) begin bad++; $display("FAIL restart_clear got=%b exp=010000", {done, busy, fail_mask, ffvalid}); end
    repeat (12) tick();
    total++; if ({done, pass} !== 2'b11) begin bad++; $display("FAIL restart_done got=%b exp=11", {done, pass}); end
  endtask

  task automatic test_start_held;
    all_nor();
    start = 1'b1; tick();
    repeat (12) tick();
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL held_done1 got=%b exp=10", {done, busy}); end
    tick();
    total++; if ({done, busy} !== 2'b01) begin bad++; $display("FAIL held_restart got=%b exp=01", {done, busy}); end
    repeat (12) tick();
    total++; if ({done, busy} !== 2'b10) begin bad++; $display("FAIL held_done2 got=%b exp=10", {done, busy}); end
    start = 1'b0; tick();
  endtask

  task automatic test_xor_fast;
    logic [1:0] eab;
    start2 = 1'b1; tick(); start2 = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      eab = (k == 9) ? 2'd3 : 2'((k - 1) / 2);
      total++; if ({a2, b2} !== eab) begin bad++; $display("FAIL xor_ab cyc=%0d got=%b exp=%b", k, {a2, b2}, eab); end
      total++; if (done2 !== (k == 9)) begin bad++; $display("FAIL xor_done cyc=%0d got=%b", k, done2); end
      if (k < 9) tick();
    end
    total++; if ({pass2, fail_mask2, ffvalid2} !== 3'b100) begin bad++; $display("FAIL xor_result got=%b exp=100", {pass2, fail_mask2, ffvalid2}); end
  endtask

  initial begin
    test_reset();
    test_all_nor();
    test_or_inst1();
    test_nand_inst2();
    test_settle_ignore();
    test_reset_mid();
    test_start_busy();
    test_start_held();
    test_xor_fast();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gate_bist.md
Name: gate_bist

Overview:
- Synthesizable, self-checking stimulus engine for 2-input gate implementations.
- Drives the exhaustive input sequence {a,b} = 00, 01, 10, 11 into up to N_DUT gate instances that share the a/b inputs.
- Waits a programmable settle time per vector, then compares each instance's output against a parameterised truth table.
- Reports pass/fail per instance. Lets the team check dataflow, behavioural and structural gate variants in hardware, not only in simulation.

Parameters:
- N_DUT, 3: number of gate outputs checked in parallel (≥1).
- SETTLE_CYCLES, 2: cycles each vector is held before sampling (≥1).
- TRUTH, 4'b0001: expected output, indexed by {a,b}; bit0 = a0b0. The default is NOR.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to run one full sweep.
- a  out  1  stimulus input A to all instances.
- b  out  1  stimulus input B to all instances.
- c_in  in  N_DUT  instance outputs; bit i belongs to instance i.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  sweep complete; sticky until next accepted start or rst.
- pass  out  1  done && fail_mask==0.
- fail_mask  out  N_DUT  bit i set if instance i mismatched on any vector.
- first_fail_vec  out  2  {a,b} of the first vector with any mismatch.
- first_fail_valid  out  1  first_fail_vec holds a captured value.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on rising clk.
  - Reset is synchronous and active-high (rst), with priority over start.
  - Reset values: a=0, b=0, busy=0, done=0, pass=0, fail_mask=0, first_fail_vec=0, first_fail_valid=0, state=IDLE.
- FSM states: IDLE, SETTLE, CHECK, DONE.
- IDLE:
  - start=1 → vec=0, {a,b}=00, settle counter=SETTLE_CYCLES-1.
  - Clears fail_mask, first_fail_valid and first_fail_vec; done=0; busy=1; goes to SETTLE.
- SETTLE:
  - Holds {a,b}=vec; decrements the counter.
  - Counter==0 → CHECK.
- CHECK (one cycle):
  - Samples c_in; mismatch[i] = c_in[i] ^ TRUTH[vec]; fail_mask |= mismatch.
  - If mismatch≠0 and !first_fail_valid: first_fail_vec=vec, first_fail_valid=1.
  - vec==3 → DONE; busy=0; done=1.
  - Otherwise vec=vec+1 (2-bit, no wrap needed), {a,b} updated, counter reloaded, → SETTLE.
- DONE:
  - Outputs held; {a,b} held at 11.
  - start=1 restarts exactly as from IDLE, clearing prior results in the same edge.
- Timing:
  - start sampled at edge T → {a,b}=00 valid in cycle T+1.
  - Each vector lasts SETTLE_CYCLES+1 cycles.
  - done first high in cycle T+1+4·(SETTLE_CYCLES+1); with defaults, T+13.
- Boundary conditions:
  - start while busy: ignored; the sweep is not restarted.
  - start held high continuously: one sweep per DONE→start acceptance; no retrigger while busy.
  - rst mid-sweep: next cycle all outputs at reset values; no partial results retained.
  - rst and start in the same cycle: rst wins; remains IDLE.
  - c_in is only sampled in CHECK; changes during SETTLE are ignored.
  - X on c_in in CHECK is treated as a mismatch by the bench; RTL behaviour is unspecified.
- pass is combinational from the done and fail_mask registers; all other outputs are registered.

Decomposition:
- Shared package holds:
  - FSM state encoding (2-bit localparams IDLE=0, SETTLE=1, CHECK=2, DONE=3).
  - Truth-table constants TT_NOR=4'b0001, TT_AND=4'b1000, TT_OR=4'b1110, TT_NAND=4'b0111, TT_XOR=4'b0110.
- One natural sub-module: bist_settle_timer, a loadable down-counter with a zero flag, width $clog2(SETTLE_CYCLES)+1.
- The comparator and FSM remain in gate_bist.

Test Plan:
- Three correct NOR instances, defaults; start pulse at T:
  - {a,b} steps 00/01/10/11, each held 3 cycles.
  - done=1 at T+13; pass=1; fail_mask=3'b000; first_fail_valid=0.
- Instance 1 replaced by OR, others NOR:
  - fail_mask=3'b010 (instance 1 wrong on every vector); first_fail_vec=2'b00; first_fail_valid=1; pass=0.
- Instance 2 replaced by NAND:
  - NAND matches NOR at 00 and 11 only, so the first mismatch is at vec 01.
  - fail_mask=3'b100; first_fail_vec=2'b01.
- rst asserted at T+7 mid-sweep:
  - T+8 shows all outputs zero and state IDLE.
  - A new start then yields a clean sweep, with done 13 cycles after that start.
- start pulsed at T+4 during a sweep, then again after done:
  - The second pulse has no effect.
  - The third pulse clears done and fail_mask next cycle and reruns; done 13 cycles later.
- SETTLE_CYCLES=1, TRUTH=TT_XOR, N_DUT=1 XOR instance:
  - Each vector lasts 2 cycles; done at T+9; pass=1.
